// File: rtl/uart_tx_ctrl_if.sv
// Host-side byte handshake for the UART transmit controller.
//   tx_data    : byte to send, sampled on the handshake edge
//   tx_valid   : source has a byte
//   tx_ready   : controller can accept a byte
//   parity_en  : insert a parity bit for this frame
//   parity_odd : 1 = odd parity, 0 = even parity
//   stop2      : 1 = two stop bits
// master = byte source, slave = uart_tx_ctrl.
interface uart_tx_ctrl_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 parity_en;
    logic                 parity_odd;
    logic                 stop2;

    modport master (
        output tx_data, tx_valid, parity_en, parity_odd, stop2,
        input  tx_ready
    );

    modport slave (
        input  tx_data, tx_valid, parity_en, parity_odd, stop2,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller. Accepts one byte per valid/ready handshake and
// serialises start bit, DATA_BITS data bits (LSB first), optional parity
// and one or two stop bits. Bit timing counts SAMPLE en_sample pulses per bit.
//   clk       : system clock
//   reset_n   : synchronous active-low reset
//   en_sample : one-clk pulse at SAMPLE x baud rate
//   host      : byte handshake + per-frame config (DATA_BITS must match)
//   tx        : serial line, idles high
//   tx_busy   : frame in progress
//   tx_done   : one-clk pulse at the end of the final stop bit
module uart_tx_ctrl #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned SAMPLE    = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en_sample,
    uart_tx_ctrl_if.slave host,
    output logic          tx,
    output logic          tx_busy,
    output logic          tx_done
);

    localparam int unsigned TW = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;
    localparam int unsigned BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                 state_q,    state_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0]   shreg_q,    shreg_d;
    logic                   parity_q,   parity_d;
    logic                   par_en_q,   par_en_d;
    logic                   stop2_q,    stop2_d;
    logic                   tx_q,       tx_d;
    logic                   ready_q,    ready_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;
    logic                   bit_end;

    assign bit_end       = en_sample && (tick_cnt_q == TW'(SAMPLE - 1));
    assign host.tx_ready = ready_q;
    assign tx            = tx_q;
    assign tx_busy       = busy_q;
    assign tx_done       = done_q;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        par_en_d   = par_en_q;
        stop2_d    = stop2_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (state_q != IDLE && en_sample) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + TW'(1);
        end

        unique case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                tx_d       = 1'b1;
                ready_d    = 1'b1;
                busy_d     = 1'b0;
                if (host.tx_valid && ready_q) begin
                    shreg_d  = host.tx_data;
                    par_en_d = host.parity_en;
                    stop2_d  = host.stop2;
                    // Odd parity folds in as an inversion of the data XOR.
                    parity_d = (^host.tx_data) ^ host.parity_odd;
                    state_d  = START;
                    tx_d     = 1'b0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Shifting keeps the next bit at index 1, avoiding a
                        // variable bit select on the captured byte.
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // bit_cnt counts stop bits here; a second one only with stop2.
                    if (stop2_q && bit_cnt_q == '0) begin
                        bit_cnt_d = BW'(1);
                    end else begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        tx_d      = 1'b1;
                        ready_d   = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl. The reference model builds each
// frame as a list of line levels and indexes it by elapsed en_sample count.
module tb_uart_tx_ctrl;

    localparam int unsigned DB = 8;
    localparam int unsigned SM = 16;

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic en_sample = 1'b0;
    logic tx, tx_busy, tx_done;
    logic en_edge   = 1'b0;
    int   en_mode   = 0;
    int   checks    = 0;
    int   errors    = 0;

    uart_tx_ctrl_if #(.DATA_BITS(DB)) host ();

    uart_tx_ctrl #(.DATA_BITS(DB), .SAMPLE(SM)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_sample (en_sample),
        .host      (host.slave),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    // en_sample: every 4th clk (mode 0) or continuously high (mode 1).
    initial begin : en_gen
        int phase;
        phase = 0;
        forever begin
            @(posedge clk);
            #1;
            phase = (phase + 1) % 4;
            en_sample = (en_mode != 0) ? 1'b1 : (phase == 0);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        en_edge = en_sample;
        #2;
    endtask

    // Sends one frame and checks every clk until tx_done. chain leaves
    // tx_valid high at the end so the next call's byte is taken immediately.
    task automatic run_frame(input string name, input logic [7:0] data,
                             input logic pen, input logic podd, input logic s2,
                             input bit noise, input bit chain, output int cycles);
        logic       frame [0:12];
        int         nb, total, k, ones;
        bit         done_seen;
        logic [3:0] obs, exp;

        ones = 0;
        frame[0] = 1'b0;
        for (int i = 0; i < DB; i++) begin
            frame[1+i] = data[i];
            ones += int'(data[i]);
        end
        nb = 1 + DB;
        if (pen) begin
            frame[nb] = ((ones % 2) == 1) ^ podd;
            nb++;
        end
        frame[nb] = 1'b1;
        nb++;
        if (s2) begin
            frame[nb] = 1'b1;
            nb++;
        end
        total = nb * SM;

        host.tx_data    = data;
        host.parity_en  = pen;
        host.parity_odd = podd;
        host.stop2      = s2;
        host.tx_valid   = 1'b1;
        step();
        k = 0;
        obs = {tx, tx_busy, host.tx_ready, tx_done};
        exp = 4'b0100;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s handshake: tx/busy/ready/done=%b expected %b", name, obs, exp);
        end

        done_seen = 1'b0;
        cycles = 0;
        for (int cyc = 0; cyc < total * 8 + 50 && !done_seen; cyc++) begin
            if (noise) begin
                host.tx_valid   = 1'($urandom);
                host.tx_data    = 8'($urandom);
                host.parity_en  = 1'($urandom);
                host.parity_odd = 1'($urandom);
                host.stop2      = 1'($urandom);
            end else begin
                host.tx_valid   = chain;
            end
            step();
            cycles++;
            if (en_edge) k++;
            if (k < total) begin
                exp = {frame[k / SM], 3'b100};
            end else begin
                exp = 4'b1011;
                done_seen = 1'b1;
            end
            obs = {tx, tx_busy, host.tx_ready, tx_done};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s tick %0d: tx/busy/ready/done=%b expected %b", name, k, obs, exp);
            end
        end
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: ticks=%0d expected %0d", name, k, total);
        end
        host.tx_valid = chain;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        reset_n       = 1'b0;
        host.tx_valid = 1'b1;
        host.tx_data  = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            step();
            obs = {tx, tx_busy, host.tx_ready, tx_done};
            checks++;
            if (obs !== 4'b1000) begin
                errors++;
                $display("FAIL reset_state: tx/busy/ready/done=%b expected 1000", obs);
            end
        end
        host.tx_valid = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            obs = {tx, tx_busy, host.tx_ready, tx_done};
            checks++;
            if (obs !== 4'b1010) begin
                errors++;
                $display("FAIL idle_after_reset: tx/busy/ready/done=%b expected 1010", obs);
            end
        end
    endtask

    task automatic test_basic();
        int cyc;
        en_mode = 0;
        run_frame("a5_plain", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cyc);
    endtask

    task automatic test_parity();
        int cyc;
        run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cyc);
        run_frame("a5_odd",  8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, cyc);
    endtask

    task automatic test_stop2();
        int cyc;
        run_frame("ff_stop2", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cyc);
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_frame("b2b_first",  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cyc);
        run_frame("b2b_second", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cyc);
        run_frame("noisy_host", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, cyc);
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs;
        int k;
        int cyc;
        host.tx_data    = 8'hC3;
        host.parity_en  = 1'b1;
        host.parity_odd = 1'b0;
        host.stop2      = 1'b0;
        host.tx_valid   = 1'b1;
        step();
        host.tx_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 2000 && k < 3 * SM; c++) begin
            step();
            if (en_edge) k++;
        end
        checks++;
        if (k != 3 * SM) begin
            errors++;
            $display("FAIL reset_mid_reach: ticks=%0d expected %0d", k, 3 * SM);
        end
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            obs = {tx, tx_busy, host.tx_ready, tx_done};
            checks++;
            if (obs !== 4'b1000) begin
                errors++;
                $display("FAIL reset_mid: tx/busy/ready/done=%b expected 1000", obs);
            end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            obs = {tx, tx_busy, host.tx_ready, tx_done};
            checks++;
            if (obs !== 4'b1010) begin
                errors++;
                $display("FAIL reset_mid_release: tx/busy/ready/done=%b expected 1010", obs);
            end
        end
        run_frame("after_reset", 8'h96, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, cyc);
    endtask

    task automatic test_en_continuous();
        int cyc;
        en_mode = 1;
        step();
        step();
        run_frame("en_cont", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, cyc);
        checks++;
        if (cyc != 11 * SM) begin
            errors++;
            $display("FAIL en_cont_length: clks=%0d expected %0d", cyc, 11 * SM);
        end
        en_mode = 0;
        step();
    endtask

    task automatic test_random();
        int cyc;
        for (int i = 0; i < 6; i++) begin
            en_mode = int'($urandom_range(0, 1));
            run_frame("random", 8'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), 1'b0, cyc);
        end
        en_mode = 0;
    endtask

    initial begin
        host.tx_valid   = 1'b0;
        host.tx_data    = '0;
        host.parity_en  = 1'b0;
        host.parity_odd = 1'b0;
        host.stop2      = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_reset_mid();
        test_en_continuous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- UART transmit controller driven by the 16x oversample tick `en_sample` from the baud/sample clock generator.
- Accepts one byte per valid/ready handshake and sequences the serial frame: start bit, DATA_BITS data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- All bit timing derives from `en_sample` pulses; the block never divides `clk` itself.
- Sits between the host-side byte source (FIFO or register interface) and the TX pin.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- SAMPLE, 16, `en_sample` pulses per bit time; must match the generator's oversample factor.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, synchronous active-low reset, sampled on rising `clk`.
- en_sample, input, 1, one-`clk` pulse at SAMPLE x baud rate.
- tx_data, input, DATA_BITS, byte to send; captured on handshake.
- tx_valid, input, 1, source has a byte.
- tx_ready, output, 1, controller can accept a byte.
- parity_en, input, 1, 1 = insert parity bit; captured on handshake.
- parity_odd, input, 1, 1 = odd parity, 0 = even; captured on handshake.
- stop2, input, 1, 1 = two stop bits; captured on handshake.
- tx, output, 1, serial line; idles high.
- tx_busy, output, 1, frame in progress.
- tx_done, output, 1, one-`clk` pulse at end of the final stop bit.

Behaviour:
- Reset (reset_n low at a `clk` edge):
  - Outputs: tx=1, tx_ready=0, tx_busy=0, tx_done=0.
  - Internal: state=IDLE, tick_cnt=0, bit_cnt=0.
- First edge after reset release: tx_ready=1.
- Reset mid-frame:
  - Frame is abandoned and tx goes high at that edge.
  - No tx_done is generated and the captured data is discarded.
- All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, tx_ready=1, tick_cnt held at 0, en_sample ignored.
  - Handshake occurs on the edge where tx_valid=1 and tx_ready=1.
  - On that edge: capture tx_data, parity_en, parity_odd and stop2; compute parity.
    - Even: XOR of data bits.
    - Odd: inverted XOR of data bits.
  - The next registered values are state=START, tx=0, tx_ready=0, tx_busy=1.
- Bit timing:
  - tick_cnt increments on each en_sample while not in IDLE.
  - A bit ends on the en_sample where tick_cnt==SAMPLE-1; tick_cnt then wraps to 0 and the state or bit advances at that edge.
  - Each bit therefore lasts exactly SAMPLE en_sample pulses after it starts, with start-bit phase jitter of less than one en_sample period.
- START → DATA at end of bit; bit_cnt=0; tx=data[0].
- DATA:
  - On each end of bit, bit_cnt increments and tx=data[bit_cnt].
  - After bit DATA_BITS-1: go to PARITY if parity_en (tx=parity bit), else go to STOP (tx=1).
- PARITY → STOP at end of bit; tx=1.
- STOP:
  - Lasts 1 bit time, or 2 bit times if stop2 (2*SAMPLE ticks).
  - At its end: state=IDLE, tx_done=1 for one `clk`, tx_busy=0, tx_ready=1 on the same edge.
- Back-to-back frames: a byte held valid is accepted on the first IDLE cycle, giving an idle gap of 1 `clk` between frames.
- tx_valid while tx_ready=0 is ignored; tx_data and config are don't-care outside the handshake edge.
- Config changes mid-frame have no effect on the current frame.
- en_sample held high continuously is legal: each `clk` then counts as one tick.

Test Plan:
- SAMPLE=16, bench pulses en_sample every 4 clk; send 0xA5 with no parity and 1 stop → tx = 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks (64 clk); tx_done 1 clk after 160 ticks; tx_busy high throughout.
- 0xA5 with parity_en=1, parity_odd=0 → parity bit 0; repeat with parity_odd=1 → parity bit 1; frame is 11 bit times.
- stop2=1 with 0xFF → tx low for the start bit only, then high for 8+2 bit times; tx_done at tick 176.
- tx_valid held high with two bytes 0x00 then 0x81 → second start bit begins 1 clk after tx_done; tx_valid pulses during the first frame are not accepted.
- Assert reset_n=0 mid-DATA → tx=1, tx_busy=0, tx_ready=0 at that edge; no tx_done; tx_ready=1 one clk after release and the next frame transmits correctly.
- en_sample held at 1 with SAMPLE=16 → each bit lasts exactly 16 clk; config inputs toggled mid-frame do not alter the frame.
